psum_accumulator: RTL and testbench
===================================

// Module: psum_accumulator
// PURPOSE
//   Column-bottom accumulation buffer, directly downstream of one MMU PE column.
//   Captures the psum stream leaving the last PE (psum_o qualified by psum_en_o).
//   Sums the stream element-wise over NUM_TILES K-tiles of DEPTH entries each.
//   Drains the DEPTH final sums through a valid/ready output port.
// PARAMETERS
//   PSUM_WIDTH  32  width of incoming psum from PE column
//   ACC_WIDTH   32  accumulator entry width (>= PSUM_WIDTH)
//   DEPTH       16  entries per tile (output rows per column)
//   ADDR_WIDTH  4   clog2(DEPTH)
//   TILE_WIDTH  8   width of tile-count input
// PORTS
//   clk          in   1           clock, rising edge
//   rst_n        in   1           asynchronous reset, active-low
//   start_i      in   1           begin a job (sampled in IDLE only)
//   num_tiles_i  in   TILE_WIDTH  K-tiles in job, sampled with start_i; 0 treated as 1
//   psum_i       in   PSUM_WIDTH  psum from last PE of column
//   psum_en_i    in   1           psum_i valid this cycle (PE psum_en_o)
//   out_data_o   out  ACC_WIDTH   accumulated result, entry rd_ptr
//   out_valid_o  out  1           out_data_o valid
//   out_ready_i  in   1           consumer accepts out_data_o
//   busy_o       out  1           state != IDLE
//   done_o       out  1           one-cycle pulse after last entry drained
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE, wr_ptr=rd_ptr=tile_cnt=0, all buffer entries 0.
//     out_data_o=0, out_valid_o=0, busy_o=0, done_o=0.
//   FSM: IDLE -> ACCUM -> DRAIN -> IDLE.
//   IDLE: start_i=1 latches num_tiles_i (0->1), clears ptrs/tile_cnt; next state ACCUM.
//     busy_o=1 from the following cycle. psum_en_i ignored in IDLE.
//   ACCUM, per cycle with psum_en_i=1:
//     tile_cnt==0: buf[wr_ptr] <= zext(psum_i) (overwrite; no clear pass needed).
//     tile_cnt>0:  buf[wr_ptr] <= buf[wr_ptr] + zext(psum_i).
//     Arithmetic unsigned, wraps modulo 2^ACC_WIDTH, no saturation, no overflow flag.
//     wr_ptr++; at wr_ptr==DEPTH-1 wr_ptr wraps to 0 and tile_cnt++.
//     Write of entry DEPTH-1 of the last tile -> DRAIN on the next cycle.
//     Cycles with psum_en_i=0 hold all state (bubbles allowed, any spacing).
//   DRAIN: out_valid_o=1, out_data_o=buf[rd_ptr] (combinational read).
//     Transfer when out_valid_o & out_ready_i; rd_ptr++ on transfer.
//     out_data_o/out_valid_o stable while out_ready_i=0.
//     Transfer of entry DEPTH-1: done_o=1 next cycle, state IDLE, out_valid_o=0.
//     psum_en_i ignored in DRAIN (data dropped; producer must not send).
//   start_i outside IDLE ignored; num_tiles_i only sampled with accepted start_i.
//   Back-to-back: start_i in the cycle done_o is high is accepted (state already IDLE).
//   Latency: last psum write -> out_valid_o high 1 cycle later.
//     First result accepted after 1 cycle if out_ready_i=1; DEPTH cycles to drain at full rate.
//   Reset mid-job: immediate return to reset values; partial sums discarded.
// TESTING
//   T1 num_tiles=1, psum_i=k+1 for k=0..15, ready=1
//      -> out_data 1..16 in order, done_o pulse after 16th transfer.
//   T2 num_tiles=3, psum_i=10*k each tile
//      -> out_data[k]=30*k; tile 0 overwrites stale data left by T1.
//   T3 num_tiles=2, entry 0 gets 0xFFFF_FFFF then 0x2
//      -> out_data[0]=0x0000_0001 (wrap).
//   T4 random psum_en_i bubbles plus ready toggling (ready=0 for 3 cycles mid-drain)
//      -> identical results to bubble-free run; out_data held while stalled.
//   T5 num_tiles=0 -> behaves as 1 tile; start_i asserted during ACCUM -> ignored.
//   T6 rst_n low after 7 writes of tile 1
//      -> all outputs 0, busy_o=0; a fresh job afterwards returns correct sums.

Source files
------------

// File: rtl/psum_accumulator_if.sv
// psum_accumulator_if: job control, PE-column psum stream and drained-result handshake.
interface psum_accumulator_if #(
  parameter int PSUM_WIDTH = 32,
  parameter int ACC_WIDTH  = 32,
  parameter int TILE_WIDTH = 8
);
  logic                  start;
  logic [TILE_WIDTH-1:0] num_tiles;
  logic [PSUM_WIDTH-1:0] psum;
  logic                  psum_en;
  logic [ACC_WIDTH-1:0]  out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
  logic                  done;
  modport master (output start, num_tiles, psum, psum_en, out_ready,
                  input out_data, out_valid, busy, done);
  modport slave (input start, num_tiles, psum, psum_en, out_ready,
                 output out_data, out_valid, busy, done);
endinterface

// File: rtl/psum_accumulator.sv
// psum_accumulator: sums a PE-column psum stream over K-tiles, then drains the
// DEPTH final sums through a valid/ready port.
module psum_accumulator #(
  parameter int PSUM_WIDTH = 32,
  parameter int ACC_WIDTH  = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int TILE_WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  psum_accumulator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;
  state_t state, state_nxt;
  logic [ACC_WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [TILE_WIDTH-1:0] tile_cnt, tiles;
  logic wr_en, wr_last, last_tile, xfer, rd_last;
  assign wr_en     = state == ACCUM && bus.psum_en;
  assign wr_last   = wr_ptr == ADDR_WIDTH'(DEPTH - 1);
  assign last_tile = tile_cnt == tiles - TILE_WIDTH'(1);
  assign xfer      = state == DRAIN && bus.out_ready;
  assign rd_last   = rd_ptr == ADDR_WIDTH'(DEPTH - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = bus.start ? ACCUM : IDLE;
      ACCUM:   state_nxt = wr_en && wr_last && last_tile ? DRAIN : ACCUM;
      DRAIN:   state_nxt = xfer && rd_last ? IDLE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.out_valid = state == DRAIN;
    bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;
    bus.busy      = state != IDLE;
  end
  // The first tile overwrites instead of adding, so stale sums need no clear pass.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tile_cnt <= '0;
      tiles    <= TILE_WIDTH'(1);
      bus.done <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      bus.done <= xfer && rd_last;
      if (state == IDLE && bus.start) begin
        tiles    <= bus.num_tiles == '0 ? TILE_WIDTH'(1) : bus.num_tiles;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        tile_cnt <= '0;
      end
      if (wr_en) begin
        mem[wr_ptr] <= (tile_cnt == '0 ? '0 : mem[wr_ptr]) + ACC_WIDTH'(bus.psum);
        wr_ptr      <= wr_last ? '0 : wr_ptr + ADDR_WIDTH'(1);
        if (wr_last) tile_cnt <= tile_cnt + TILE_WIDTH'(1);
      end
      if (xfer) rd_ptr <= rd_last ? '0 : rd_ptr + ADDR_WIDTH'(1);
    end
endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: directed tests of tile accumulation, wrap, bubbles, stalls and reset.
module tb_psum_accumulator;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] got [DEPTH];
  logic [31:0] stall_d [3];
  int got_n;
  psum_accumulator_if bus ();
  psum_accumulator dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic start_job(input logic [7:0] n);
    bus.start = 1'b1;
    bus.num_tiles = n;
    @(negedge clk);
    bus.start = 1'b0;
    bus.num_tiles = 8'hAA;
  endtask

  task automatic feed(input logic [31:0] v, input int gap);
    bus.psum_en = 1'b0;
    repeat (gap) @(negedge clk);
    bus.psum = v;
    bus.psum_en = 1'b1;
    @(negedge clk);
    bus.psum_en = 1'b0;
  endtask

  task automatic drain(input int stall_at);
    int st = 0;
    got_n = 0;
    for (int c = 0; c < 200 && got_n < DEPTH; c++) begin
      if (got_n == stall_at && st < 3) begin
        bus.out_ready = 1'b0;
        stall_d[st] = bus.out_data;
        st++;
      end else begin
        bus.out_ready = 1'b1;
        if (bus.out_valid) begin
          got[got_n] = bus.out_data;
          got_n++;
        end
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h expected 0", bus.out_data); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", bus.done); end
    rst_n = 1'b1;
    bus.psum = 32'd99;
    bus.psum_en = 1'b1;
    repeat (2) @(negedge clk);
    bus.psum_en = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_psum_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_single_tile;
    start_job(8'd1);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL t1_busy: got %b expected 1", bus.busy); end
    for (int k = 0; k < DEPTH; k++) feed(32'(k + 1), 0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL t1_valid_latency: got %b expected 1", bus.out_valid); end
    drain(-1);
    checks++; if (got_n != DEPTH) begin errors++; $display("FAIL t1_count: got %0d expected %0d", got_n, DEPTH); end
    for (int k = 0; k < got_n; k++) begin
      checks++; if (got[k] !== 32'(k + 1)) begin errors++; $display("FAIL t1_data[%0d]: got %h expected %h", k, got[k], 32'(k + 1)); end
    end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL t1_done: got %b expected 1", bus.done); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_after: got %b expected 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL t1_busy_after: got %b expected 0", bus.busy); end
  endtask

  task automatic test_back_to_back;
    start_job(8'd3);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_done_pulse: got %b expected 0", bus.done); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", bus.busy); end
    for (int t = 0; t < 3; t++)
      for (int k = 0; k < DEPTH; k++) feed(32'(10 * k), 0);
    drain(-1);
    checks++; if (got_n != DEPTH) begin errors++; $display("FAIL t2_count: got %0d expected %0d", got_n, DEPTH); end
    for (int k = 0; k < got_n; k++) begin
      checks++; if (got[k] !== 32'(30 * k)) begin errors++; $display("FAIL t2_data[%0d]: got %h expected %h", k, got[k], 32'(30 * k)); end
    end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    start_job(8'd2);
    for (int k = 0; k < DEPTH; k++) feed(k == 0 ? 32'hFFFF_FFFF : 32'h0, 0);
    for (int k = 0; k < DEPTH; k++) feed(k == 0 ? 32'h2 : 32'(k), 0);
    drain(-1);
    checks++; if (got_n != DEPTH) begin errors++; $display("FAIL t3_count: got %0d expected %0d", got_n, DEPTH); end
    for (int k = 0; k < got_n; k++) begin
      checks++; if (got[k] !== (k == 0 ? 32'h1 : 32'(k))) begin errors++; $display("FAIL t3_data[%0d]: got %h expected %h", k, got[k], k == 0 ? 32'h1 : 32'(k)); end
    end
  endtask

  task automatic test_bubbles;
    @(negedge clk);
    start_job(8'd2);
    for (int k = 0; k < DEPTH; k++) feed(32'(7 * k + 3), k % 3);
    for (int k = 0; k < DEPTH; k++) feed(32'(5 * k), (k + 1) % 2);
    drain(5);
    checks++; if (got_n != DEPTH) begin errors++; $display("FAIL t4_count: got %0d expected %0d", got_n, DEPTH); end
    for (int k = 0; k < got_n; k++) begin
      checks++; if (got[k] !== 32'(12 * k + 3)) begin errors++; $display("FAIL t4_data[%0d]: got %h expected %h", k, got[k], 32'(12 * k + 3)); end
    end
    for (int s = 0; s < 3; s++) begin
      checks++; if (stall_d[s] !== 32'd63) begin errors++; $display("FAIL t4_stall_hold[%0d]: got %h expected %h", s, stall_d[s], 32'd63); end
    end
  endtask

  task automatic test_zero_tiles;
    @(negedge clk);
    start_job(8'd0);
    for (int k = 0; k < 8; k++) feed(32'(k + 50), 0);
    bus.start = 1'b1;
    bus.num_tiles = 8'd4;
    for (int k = 8; k < DEPTH; k++) feed(32'(k + 50), 0);
    bus.start = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL t5_drain_after_one_tile: got %b expected 1", bus.out_valid); end
    drain(-1);
    checks++; if (got_n != DEPTH) begin errors++; $display("FAIL t5_count: got %0d expected %0d", got_n, DEPTH); end
    for (int k = 0; k < got_n; k++) begin
      checks++; if (got[k] !== 32'(k + 50)) begin errors++; $display("FAIL t5_data[%0d]: got %h expected %h", k, got[k], 32'(k + 50)); end
    end
  endtask

  task automatic test_reset_mid_job;
    @(negedge clk);
    start_job(8'd2);
    for (int k = 0; k < DEPTH; k++) feed(32'(k + 100), 0);
    for (int k = 0; k < 7; k++) feed(32'(k + 200), 0);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL t6_rst_data: got %h expected 0", bus.out_data); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t6_rst_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL t6_rst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL t6_rst_done: got %b expected 0", bus.done); end
    @(negedge clk);
    rst_n = 1'b1;
    start_job(8'd2);
    for (int k = 0; k < DEPTH; k++) feed(32'(k), 0);
    for (int k = 0; k < DEPTH; k++) feed(32'(2 * k), 0);
    drain(-1);
    checks++; if (got_n != DEPTH) begin errors++; $display("FAIL t6_count: got %0d expected %0d", got_n, DEPTH); end
    for (int k = 0; k < got_n; k++) begin
      checks++; if (got[k] !== 32'(3 * k)) begin errors++; $display("FAIL t6_data[%0d]: got %h expected %h", k, got[k], 32'(3 * k)); end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.num_tiles = '0;
    bus.psum = '0;
    bus.psum_en = 1'b0;
    bus.out_ready = 1'b0;
    test_reset;
    @(negedge clk);
    test_single_tile;
    test_back_to_back;
    test_wrap;
    test_bubbles;
    test_zero_tiles;
    test_reset_mid_job;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end
endmodule
